mtr_pwm_drv: RTL

Drive stage directly downstream of the balance PID controller. It takes the saturated signed 12-bit `PID_cntrl` and the soft-start timer `ss_tmr`, and scales the control effort by soft-start. It mixes in steering, applies dead-zone compensation, saturates, and generates complementary PWM pairs for the left and right motor H-bridges, with non-overlap dead time.

---
 rtl/mtr_pkg.sv | 41 ++++
 rtl/mtr_pwm_drv_pwm11.sv | 38 +++
 rtl/mtr_pwm_drv.sv | 96 +++++++++
 3 files changed

// File: rtl/mtr_pkg.sv
// Shared constants and arithmetic helpers for the motor PWM drive stage.
// The DEADZONE_COMP_EN macro selects dead-zone compensating shaping in shape().
package mtr_pkg;

  localparam logic signed [13:0] MIN_DUTY        = 14'sd980;
  localparam logic signed [13:0] LOW_TORQUE_BAND = 14'sd42;
  localparam logic signed [13:0] GAIN_MULT       = 14'sd6;
  localparam logic signed [11:0] TOO_FAST_THR    = 12'sh600;
  localparam logic [10:0]        DUTY_STOP       = 11'h400;
  localparam logic [11:0]        STEER_MIN       = 12'h200;
  localparam logic [11:0]        STEER_MAX       = 12'hE00;
  localparam logic signed [12:0] STEER_MID       = 13'sd2047;

  function automatic logic signed [11:0] sat12(input logic signed [13:0] v);
    if (v > 14'sd2047)       return 12'sh7FF;
    else if (v < -14'sd2048) return 12'sh800;
    else                     return 12'(v);
  endfunction

  function automatic logic signed [11:0] shape(input logic signed [12:0] trq);
`ifdef DEADZONE_COMP_EN
    logic signed [13:0] t;
    t = 14'(trq);
    // Outside the band the motor needs a minimum duty to overcome stiction;
    // inside it a plain gain keeps the response continuous through zero.
    if (t > LOW_TORQUE_BAND || t < -LOW_TORQUE_BAND)
      return sat12(t[13] ? t - MIN_DUTY : t + MIN_DUTY);
    return sat12(t * GAIN_MULT);
`else
    return sat12(14'(trq));
`endif
  endfunction

  // Offset-binary: 0x800 added to the signed value, then halved to 11 bits.
  function automatic logic [10:0] to_duty(input logic signed [11:0] s);
    logic [11:0] b;
    b = 12'(s) ^ 12'h800;
    return 11'(b >> 1);
  endfunction

endpackage

// File: rtl/mtr_pwm_drv_pwm11.sv
// One H-bridge side: duty shadow register plus complementary compare with
// dead time against the shared 11-bit period counter.
module pwm11
  import mtr_pkg::*;
#(
  parameter logic [10:0] NONOVERLAP = 11'h020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwr_up,
  input  logic [10:0] cnt,
  input  logic [10:0] duty_pend,
  output logic        pwm1,
  output logic        pwm2
);

  logic [10:0] duty;
  logic [11:0] off_edge;

  // 12-bit sum so a duty near full scale pushes the low-side edge past the
  // end of the period instead of wrapping to the start.
  assign off_edge = {1'b0, duty} + {1'b0, NONOVERLAP};

  always_ff @(posedge clk) begin
    if (rst || !pwr_up) begin
      duty <= DUTY_STOP;
      pwm1 <= 1'b0;
      pwm2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so the compares below still see the
      // pre-edge duty even on the wrap cycle when the shadow reloads.
      if (cnt == 11'h7FF) duty <= duty_pend;
      pwm1 <= (cnt >= NONOVERLAP) && (cnt < duty);
      pwm2 <= ({1'b0, cnt} >= off_edge);
    end
  end

endmodule

// File: rtl/mtr_pwm_drv.sv
// Motor drive stage: soft-start scaling, steering mix, shaping, saturation and
// edge-aligned complementary PWM. Define DEADZONE_COMP_EN for dead-zone shaping.
module mtr_pwm_drv
  import mtr_pkg::*;
#(
  parameter logic [10:0] NONOVERLAP = 11'h020
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic signed [11:0] PID_cntrl,
  input  logic [7:0]         ss_tmr,
  input  logic [11:0]        steer_pot,
  input  logic               en_steer,
  input  logic               pwr_up,
  output logic               lft_PWM1,
  output logic               lft_PWM2,
  output logic               rght_PWM1,
  output logic               rght_PWM2,
  output logic               too_fast
);

  logic [10:0]        cnt;
  logic signed [20:0] prod;
  logic signed [11:0] pid_ss;
  logic [11:0]        pot_clip;
  logic signed [12:0] steer_off;
  logic signed [14:0] steer3;
  logic signed [12:0] steer;
  logic               s1_vld;
  logic signed [12:0] lft_trq, rght_trq;
  logic signed [11:0] lft_shp, rght_shp;
  logic signed [11:0] lft_shp_nxt, rght_shp_nxt;

  // NOTE: every variable here is assigned on every path, so no latch is inferred.
  always_comb begin
    prod      = 21'(PID_cntrl) * 21'($signed({1'b0, ss_tmr}));
    pid_ss    = 12'(prod >>> 8);
    pot_clip  = (steer_pot < STEER_MIN) ? STEER_MIN :
                (steer_pot > STEER_MAX) ? STEER_MAX : steer_pot;
    steer_off = $signed({1'b0, pot_clip}) - STEER_MID;
    steer3    = 15'(steer_off) * 15'sd3;
    steer     = en_steer ? 13'(steer3 >>> 4) : 13'sd0;
  end

  assign lft_shp_nxt  = shape(lft_trq);
  assign rght_shp_nxt = shape(rght_trq);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 11'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || !pwr_up) begin
      s1_vld   <= 1'b0;
      lft_trq  <= '0;
      rght_trq <= '0;
      lft_shp  <= '0;
      rght_shp <= '0;
      too_fast <= 1'b0;
    end else begin
      s1_vld <= vld;
      if (vld) begin
        lft_trq  <= 13'(pid_ss) + steer;
        rght_trq <= 13'(pid_ss) - steer;
      end
      if (s1_vld) begin
        lft_shp  <= lft_shp_nxt;
        rght_shp <= rght_shp_nxt;
        too_fast <= (lft_shp_nxt > TOO_FAST_THR) || (rght_shp_nxt > TOO_FAST_THR);
      end
    end
  end

  pwm11 #(.NONOVERLAP(NONOVERLAP)) u_lft (
    .clk       (clk),
    .rst       (rst),
    .pwr_up    (pwr_up),
    .cnt       (cnt),
    .duty_pend (to_duty(lft_shp)),
    .pwm1      (lft_PWM1),
    .pwm2      (lft_PWM2)
  );

  pwm11 #(.NONOVERLAP(NONOVERLAP)) u_rght (
    .clk       (clk),
    .rst       (rst),
    .pwr_up    (pwr_up),
    .cnt       (cnt),
    .duty_pend (to_duty(rght_shp)),
    .pwm1      (rght_PWM1),
    .pwm2      (rght_PWM2)
  );

endmodule
